// File: rtl/branch_predictor_btb.sv
// IF-stage branch target buffer with 2-bit saturating counters. It keeps an IF->ID shadow of each
// prediction, checks it against the resolved outcome in ID, trains the table and counts events.
module branch_predictor_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   fetch_pc,
    input  logic              fetch_valid,
    input  logic              if_id_write,
    input  logic              if_id_flush,
    input  logic              id_stall,
    input  logic              id_is_ctrl,
    input  logic              id_taken,
    input  logic [XLEN-1:0]   id_target,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_next_pc,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [PERF_W-1:0] cnt_ctrl,
    output logic [PERF_W-1:0] cnt_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [XLEN-1:0]   pc_step  = XLEN'(4);
    localparam logic [PERF_W-1:0] perf_one = PERF_W'(1);
    localparam logic [PERF_W-1:0] perf_max = '1;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [XLEN-1:0]   target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic              id_pred_taken;
    logic [XLEN-1:0]   id_pred_target;

    logic [IDX_W-1:0]  fetch_idx;
    logic [TAG_W-1:0]  fetch_tag;
    logic              fetch_hit;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              res_en;
    logic              wrong;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[IDX_W+2+TAG_W-1:IDX_W+2];
    assign upd_idx   = id_pc[IDX_W+1:2];
    assign upd_tag   = id_pc[IDX_W+2+TAG_W-1:IDX_W+2];

    // Lookup reads the pre-edge table; a same-index update lands at the edge.
    always_comb begin
        fetch_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        pred_taken   = fetch_valid && fetch_hit && ctr_q[fetch_idx][1];
        pred_next_pc = pred_taken ? target_q[fetch_idx] : fetch_pc + pc_step;
    end

    always_comb begin
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        res_en  = id_valid && !id_stall;
        if (id_is_ctrl) begin
            wrong = (id_taken != id_pred_taken) ||
                    (id_taken && (id_target != id_pred_target));
        end else begin
            // A non-branch that hit a taken entry is an alias and must be undone.
            wrong = id_pred_taken;
        end
        mispredict  = res_en && wrong;
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = (id_is_ctrl && id_taken) ? id_target : id_pc + pc_step;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_pred_taken  <= 1'b0;
            id_pred_target <= '0;
        end else if (mispredict || if_id_flush) begin
            id_valid <= 1'b0;
        end else if (if_id_write) begin
            id_valid       <= fetch_valid;
            id_pc          <= fetch_pc;
            id_pred_taken  <= pred_taken;
            id_pred_target <= pred_next_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (res_en) begin
            if (id_is_ctrl) begin
                if (upd_hit) begin
                    if (id_taken) begin
                        if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                    end else begin
                        if (ctr_q[upd_idx] != 2'b00) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                    end
                end else if (id_taken) begin
                    valid_q[upd_idx] <= 1'b1;
                    ctr_q[upd_idx]   <= 2'b10;
                end
            end else if (id_pred_taken) begin
                valid_q[upd_idx] <= 1'b0;
            end
        end
    end

    // Tags and targets need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (res_en && id_is_ctrl && id_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= id_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_ctrl    <= '0;
            cnt_mispred <= '0;
        end else if (res_en) begin
            if (id_is_ctrl && (cnt_ctrl != perf_max)) cnt_ctrl <= cnt_ctrl + perf_one;
            if (mispredict && (cnt_mispred != perf_max)) cnt_mispred <= cnt_mispred + perf_one;
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: cold allocate, training, hysteresis, alias kill,
// stall/flush behaviour and asynchronous reset in mid-run.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_valid = 1'b0;
    logic        if_id_write = 1'b0;
    logic        if_id_flush = 1'b0;
    logic        id_stall = 1'b0;
    logic        id_is_ctrl = 1'b0;
    logic        id_taken = 1'b0;
    logic [31:0] id_target = '0;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] cnt_ctrl;
    logic [15:0] cnt_mispred;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    branch_predictor_btb dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_pc     (fetch_pc),
        .fetch_valid  (fetch_valid),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_stall     (id_stall),
        .id_is_ctrl   (id_is_ctrl),
        .id_taken     (id_taken),
        .id_target    (id_target),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc),
        .cnt_ctrl     (cnt_ctrl),
        .cnt_mispred  (cnt_mispred)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic set_fetch(input logic [31:0] pc, input logic v);
        fetch_pc    = pc;
        fetch_valid = v;
    endtask

    task automatic set_id(input logic c, input logic t, input logic [31:0] tg);
        id_is_ctrl = c;
        id_taken   = t;
        id_target  = tg;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        e = exp_q.pop_front();
        n_checks++;
        assert (obs === e) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, e);
        end
    endtask

    initial begin
        set_fetch(32'h40, 1'b1);
        #1;
        check("rst_pred_taken", pred_taken, 0);
        check("rst_pred_next", pred_next_pc, 32'h44);
        check("rst_mispredict", mispredict, 0);
        check("rst_redirect", redirect_pc, 0);
        check("rst_cnt_ctrl", cnt_ctrl, 0);
        check("rst_cnt_mispred", cnt_mispred, 0);
        next_cycle();
        reset = 1'b1;
        if_id_write = 1'b1;

        // Cold taken branch at 0x40
        set_fetch(32'h40, 1'b1); set_id(0, 0, 0); #1;
        check("cold_pred_taken", pred_taken, 0);
        check("cold_pred_next", pred_next_pc, 32'h44);
        check("cold_no_mispredict", mispredict, 0);
        next_cycle();
        set_fetch(32'h44, 1'b0); set_id(1, 1, 32'h80); #1;
        check("cold_mispredict", mispredict, 1);
        check("cold_redirect", redirect_pc, 32'h80);
        next_cycle();

        // Trained hit, then saturation at 3
        set_fetch(32'h40, 1'b1); set_id(0, 0, 0); #1;
        check("cold_flushed_id", mispredict, 0);
        check("cold_cnt_ctrl", cnt_ctrl, 1);
        check("cold_cnt_mispred", cnt_mispred, 1);
        check("hit_pred_taken", pred_taken, 1);
        check("hit_pred_next", pred_next_pc, 32'h80);
        next_cycle();
        set_fetch(32'h40, 1'b1); set_id(1, 1, 32'h80); #1;
        check("hit_no_mispredict", mispredict, 0);
        check("hit_redirect_zero", redirect_pc, 0);
        next_cycle();
        set_fetch(32'h40, 1'b1); set_id(1, 1, 32'h80); #1;
        check("sat_no_mispredict", mispredict, 0);
        check("sat_cnt_ctrl", cnt_ctrl, 2);
        next_cycle();

        // Hysteresis: two not-taken resolutions from ctr=3
        set_fetch(32'h40, 1'b1); set_id(1, 0, 0); #1;
        check("hyst1_pred_taken", pred_taken, 1);
        check("hyst1_mispredict", mispredict, 1);
        check("hyst1_redirect", redirect_pc, 32'h44);
        check("hyst1_cnt_ctrl", cnt_ctrl, 3);
        check("hyst1_cnt_mispred", cnt_mispred, 1);
        next_cycle();
        set_fetch(32'h40, 1'b1); set_id(0, 0, 0); #1;
        check("hyst_ctr2_pred_taken", pred_taken, 1);
        check("hyst1_cnt_ctrl_after", cnt_ctrl, 4);
        check("hyst1_cnt_mispred_after", cnt_mispred, 2);
        next_cycle();
        set_fetch(32'h44, 1'b0); set_id(1, 0, 0); #1;
        check("hyst2_mispredict", mispredict, 1);
        check("hyst2_redirect", redirect_pc, 32'h44);
        next_cycle();
        set_fetch(32'h40, 1'b1); set_id(0, 0, 0); #1;
        check("hyst_ctr1_pred_taken", pred_taken, 0);
        check("hyst_ctr1_pred_next", pred_next_pc, 32'h44);
        check("hyst2_cnt_ctrl", cnt_ctrl, 5);
        check("hyst2_cnt_mispred", cnt_mispred, 3);
        next_cycle();
        set_fetch(32'h44, 1'b0); set_id(1, 0, 0); #1;
        check("nt_correct_no_mispredict", mispredict, 0);
        next_cycle();

        // Alias kill: 0x4048 shares index 2 and tag 1 with 0x48
        set_fetch(32'h48, 1'b1); set_id(0, 0, 0); #1;
        check("alias_cold_pred", pred_taken, 0);
        check("alias_cnt_ctrl_pre", cnt_ctrl, 6);
        next_cycle();
        set_fetch(32'h4c, 1'b0); set_id(1, 1, 32'h100); #1;
        check("alias_alloc_mispredict", mispredict, 1);
        check("alias_alloc_redirect", redirect_pc, 32'h100);
        next_cycle();
        set_fetch(32'h4048, 1'b1); set_id(0, 0, 0); #1;
        check("alias_pred_taken", pred_taken, 1);
        check("alias_pred_next", pred_next_pc, 32'h100);
        check("alias_cnt_ctrl", cnt_ctrl, 7);
        check("alias_cnt_mispred", cnt_mispred, 4);
        next_cycle();
        set_fetch(32'h404c, 1'b0); set_id(0, 0, 0); #1;
        check("alias_mispredict", mispredict, 1);
        check("alias_redirect", redirect_pc, 32'h404c);
        next_cycle();
        set_fetch(32'h48, 1'b1); set_id(0, 0, 0); #1;
        check("alias_killed_pred", pred_taken, 0);
        check("alias_killed_next", pred_next_pc, 32'h4c);
        check("alias_cnt_ctrl_kept", cnt_ctrl, 7);
        check("alias_cnt_mispred_after", cnt_mispred, 5);
        next_cycle();

        // Stall: predicted-taken branch at 0x4C held in ID for three cycles
        set_fetch(32'h4c, 1'b1); set_id(0, 0, 0); #1;
        check("nonctrl_no_mispredict", mispredict, 0);
        next_cycle();
        set_fetch(32'h50, 1'b0); set_id(1, 1, 32'h200); #1;
        check("stall_alloc_redirect", redirect_pc, 32'h200);
        next_cycle();
        set_fetch(32'h4c, 1'b1); set_id(0, 0, 0); #1;
        check("stall_pred_taken", pred_taken, 1);
        check("stall_cnt_ctrl_pre", cnt_ctrl, 8);
        check("stall_cnt_mispred_pre", cnt_mispred, 6);
        next_cycle();
        if_id_write = 1'b0;
        id_stall = 1'b1;
        set_fetch(32'h200, 1'b0); set_id(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_no_mispredict", mispredict, 0);
            check("stall_redirect_zero", redirect_pc, 0);
            next_cycle();
        end
        check("stall_cnt_ctrl_held", cnt_ctrl, 8);
        check("stall_cnt_mispred_held", cnt_mispred, 6);
        id_stall = 1'b0;
        if_id_write = 1'b1;
        #1;
        check("unstall_mispredict", mispredict, 1);
        check("unstall_redirect", redirect_pc, 32'h50);
        next_cycle();
        set_fetch(32'h4c, 1'b1); set_id(0, 0, 0); #1;
        check("unstall_once_no_mispredict", mispredict, 0);
        check("unstall_cnt_ctrl", cnt_ctrl, 9);
        check("unstall_cnt_mispred", cnt_mispred, 7);
        check("unstall_ctr1_pred", pred_taken, 0);
        next_cycle();

        // Flush clears the shadow so nothing resolves
        set_fetch(32'h4c, 1'b1); set_id(0, 0, 0); if_id_flush = 1'b1; #1;
        check("flush_cycle_no_mispredict", mispredict, 0);
        next_cycle();
        if_id_flush = 1'b0;
        set_fetch(32'h50, 1'b0); set_id(1, 1, 32'h200); #1;
        check("flush_no_mispredict", mispredict, 0);
        check("flush_redirect_zero", redirect_pc, 0);
        next_cycle();
        set_fetch(32'h4c, 1'b1); set_id(0, 0, 0); #1;
        check("flush_no_update_pred", pred_taken, 0);
        check("flush_cnt_ctrl", cnt_ctrl, 9);
        check("flush_cnt_mispred", cnt_mispred, 7);
        next_cycle();

        // Retrain 0x4C to taken, then assert reset between edges
        set_fetch(32'h50, 1'b0); set_id(1, 1, 32'h200); #1;
        check("retrain_mispredict", mispredict, 1);
        next_cycle();
        set_fetch(32'h4c, 1'b1); set_id(0, 0, 0); #1;
        check("retrain_pred_taken", pred_taken, 1);
        check("retrain_cnt_ctrl", cnt_ctrl, 10);
        check("retrain_cnt_mispred", cnt_mispred, 8);
        next_cycle();
        set_fetch(32'h4c, 1'b1); set_id(1, 0, 0); #1;
        check("pre_reset_mispredict", mispredict, 1);
        check("pre_reset_pred_taken", pred_taken, 1);
        reset = 1'b0;
        #1;
        check("async_pred_taken", pred_taken, 0);
        check("async_pred_next", pred_next_pc, 32'h50);
        check("async_mispredict", mispredict, 0);
        check("async_redirect", redirect_pc, 0);
        check("async_cnt_ctrl", cnt_ctrl, 0);
        check("async_cnt_mispred", cnt_mispred, 0);
        reset = 1'b1;
        #1;
        check("post_reset_miss", pred_taken, 0);
        check("post_reset_mispredict", mispredict, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
